cmd_seq_master: RTL and testbench

//  Hardware command sequencer sitting in front of CommMaster, for bench and

---
 rtl/cmd_seq_master.sv | 237 +++++++++++++++++++++++
 tb/tb_cmd_seq_master.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_seq_master.sv
// Command table sequencer in front of CommMaster.
// Sends each entry, checks the reply, retries on timeout.
module cmd_seq_master #(
  parameter int DEPTH     = 16,
  parameter int CMD_W     = 8,
  parameter int DATA_W    = 16,
  parameter int RESP_W    = 8,
  parameter int TIMEOUT   = 1_000_000,
  parameter int MAX_RETRY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [CMD_W-1:0]         wr_cmd,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [RESP_W-1:0]        wr_exp,
  input  logic                     wr_chk,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     start,
  input  logic                     abort,
  output logic [CMD_W-1:0]         cmd,
  output logic [DATA_W-1:0]        data,
  output logic                     snd_cmd,
  input  logic                     frm_snt,
  input  logic                     resp_rdy,
  input  logic [RESP_W-1:0]        resp,
  output logic                     clr_resp_rdy,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic [1:0]               err_code,
  output logic [7:0]               n_retries
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WSNT,
    S_WRESP,
    S_CHECK,
    S_FIN
  } state_t;

  logic [CMD_W-1:0]  cmd_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [RESP_W-1:0] exp_mem  [DEPTH];
  logic              chk_mem  [DEPTH];

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     len_c;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RESP_W-1:0] exp_q, exp_d;
  logic              chk_q, chk_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [7:0]        retry_q, retry_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [7:0]        nret_q, nret_d;
  logic [1:0]        err_q, err_d;
  logic              pass_q, pass_d;
  logic [AW-1:0]     fidx_q, fidx_d;
  logic              go_fin;
  logic [1:0]        fin_err;
  logic              last;
  logic              t_out;

  // Table is writable only while idle and is never reset.
  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE) begin
      cmd_mem[wr_addr]  <= wr_cmd;
      data_mem[wr_addr] <= wr_data;
      exp_mem[wr_addr]  <= wr_exp;
      chk_mem[wr_addr]  <= wr_chk;
    end
  end

  assign len_c = (len > LW'(DEPTH)) ?
                 LW'(DEPTH) : len;
  assign last  = ({1'b0, idx_q} ==
                  (len_q - LW'(1)));
  assign t_out = (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    exp_d   = exp_q;
    chk_d   = chk_q;
    resp_d  = resp_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    nret_d  = nret_q;
    err_d   = err_q;
    pass_d  = pass_q;
    fidx_d  = fidx_q;
    go_fin  = 1'b0;
    fin_err = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d  = len_c;
          idx_d  = '0;
          nret_d = '0;
          if (len_c == '0) begin
            go_fin = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        cmd_d   = cmd_mem[idx_q];
        data_d  = data_mem[idx_q];
        exp_d   = exp_mem[idx_q];
        chk_d   = chk_mem[idx_q];
        retry_d = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        state_d = S_WSNT;
      end
      S_WSNT: begin
        if (frm_snt) begin
          cnt_d   = '0;
          state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        cnt_d = cnt_q + 1'b1;
        // A reply on the deadline cycle still counts.
        if (resp_rdy) begin
          resp_d  = resp;
          state_d = S_CHECK;
        end else if (t_out) begin
          if (retry_q < 8'(MAX_RETRY)) begin
            retry_d = retry_q + 8'd1;
            nret_d  = (nret_q == 8'hFF) ?
                      nret_q : nret_q + 8'd1;
            state_d = S_SEND;
          end else begin
            go_fin  = 1'b1;
            fin_err = 2'd2;
          end
        end
      end
      S_CHECK: begin
        if (chk_q && resp_q != exp_q) begin
          go_fin  = 1'b1;
          fin_err = 2'd1;
        end else if (last) begin
          go_fin = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && state_q != S_IDLE &&
        state_q != S_FIN) begin
      idx_d   = idx_q;
      retry_d = retry_q;
      nret_d  = nret_q;
      go_fin  = 1'b1;
      fin_err = 2'd3;
    end
    if (go_fin) begin
      state_d = S_FIN;
      err_d   = fin_err;
      pass_d  = (fin_err == 2'd0);
      fidx_d  = (fin_err == 2'd0) ?
                '0 : idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      exp_q   <= '0;
      chk_q   <= 1'b0;
      resp_q  <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      nret_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      exp_q   <= exp_d;
      chk_q   <= chk_d;
      resp_q  <= resp_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      nret_q  <= nret_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fidx_q  <= fidx_d;
    end
  end

  assign cmd          = cmd_q;
  assign data         = data_q;
  assign snd_cmd      = (state_q == S_SEND);
  assign clr_resp_rdy = (state_q == S_CHECK);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign pass         = pass_q;
  assign fail_idx     = fidx_q;
  assign err_code     = err_q;
  assign n_retries    = nret_q;

endmodule

// File: tb/tb_cmd_seq_master.sv
// Bench for cmd_seq_master: a CommMaster/copter responder
// plus a per-run reference model of the command sequence.
module tb_cmd_seq_master;
  localparam int TO = 64;
  localparam int MR = 2;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_cmd;
  logic [15:0] wr_data;
  logic [7:0]  wr_exp;
  logic        wr_chk;
  logic [4:0]  len;
  logic        start;
  logic        abort;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        snd_cmd;
  logic        frm_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        clr_resp_rdy;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  fail_idx;
  logic [1:0]  err_code;
  logic [7:0]  n_retries;

  cmd_seq_master #(
    .DEPTH(16), .CMD_W(8), .DATA_W(16), .RESP_W(8),
    .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_cmd(wr_cmd), .wr_data(wr_data),
    .wr_exp(wr_exp), .wr_chk(wr_chk),
    .len(len), .start(start), .abort(abort),
    .cmd(cmd), .data(data), .snd_cmd(snd_cmd),
    .frm_snt(frm_snt), .resp_rdy(resp_rdy),
    .resp(resp), .clr_resp_rdy(clr_resp_rdy),
    .busy(busy), .done(done), .pass(pass),
    .fail_idx(fail_idx), .err_code(err_code),
    .n_retries(n_retries)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  t_cmd [16];
  logic [15:0] t_dat [16];
  logic [7:0]  t_exp [16];
  bit          t_chk [16];
  logic [7:0]  rsp_by_cmd [256];
  int          drop_by_cmd [256];
  bit          exact_to;
  bit          hold_snt;
  int          run_id;

  logic [7:0]  snd_op_q [$];
  logic [15:0] snd_dat_q [$];
  int n_clr = 0;
  int n_done = 0;
  int clr0;
  int lat;

  logic [7:0]  exp_op_q [$];
  logic [15:0] exp_dat_q [$];
  int e_pass, e_err, e_fidx, e_nret, e_nresp;
  int o_pass, o_err, o_fidx, o_nret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $error("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    forever begin
      @(negedge clk);
      if (clr_resp_rdy === 1'b1) n_clr++;
      if (done === 1'b1) n_done++;
    end
  end

  // CommMaster + copter: answers per opcode, may drop replies.
  initial begin
    logic [7:0] op;
    int d1, d2, my_run;
    int dropped [256];
    frm_snt = 1'b0;
    resp_rdy = 1'b0;
    resp = 8'h00;
    my_run = -1;
    forever begin
      @(negedge clk);
      if (my_run != run_id) begin
        my_run = run_id;
        foreach (dropped[k]) dropped[k] = 0;
      end
      if (snd_cmd === 1'b1) begin
        op = cmd;
        snd_op_q.push_back(cmd);
        snd_dat_q.push_back(data);
        if (!hold_snt) begin
          d1 = $urandom_range(0, 3);
          repeat (d1 + 1) @(negedge clk);
          if (busy === 1'b1) begin
            frm_snt = 1'b1;
            @(negedge clk);
            frm_snt = 1'b0;
            if (dropped[op] < drop_by_cmd[op]) begin
              dropped[op]++;
            end else begin
              d2 = exact_to ? TO - 1 : $urandom_range(0, 10);
              repeat (d2) @(negedge clk);
              if (busy === 1'b1) begin
                resp = rsp_by_cmd[op];
                resp_rdy = 1'b1;
                for (int k = 0; k < 8; k++) begin
                  @(negedge clk);
                  if (clr_resp_rdy === 1'b1 || busy !== 1'b1) break;
                end
                resp_rdy = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [42:0] outs();
    return {cmd, data, snd_cmd, clr_resp_rdy, busy, done,
            pass, fail_idx, err_code, n_retries};
  endfunction

  task automatic clear_plan();
    for (int k = 0; k < 256; k++) begin
      rsp_by_cmd[k] = 8'h00;
      drop_by_cmd[k] = 0;
    end
  endtask

  task automatic wr(input int a, input logic [7:0] c,
                    input logic [15:0] d, input logic [7:0] e,
                    input bit k);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_cmd = c;
    wr_data = d;
    wr_exp = e;
    wr_chk = k;
    @(negedge clk);
    wr_en = 1'b0;
    t_cmd[a] = c;
    t_dat[a] = d;
    t_exp[a] = e;
    t_chk[a] = k;
  endtask

  task automatic start_run(input int l);
    run_id++;
    snd_op_q.delete();
    snd_dat_q.delete();
    clr0 = n_clr;
    len = 5'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    lat = c;
    check({tag, "_done"}, done, 1);
    o_pass = pass;
    o_err = err_code;
    o_fidx = fail_idx;
    o_nret = n_retries;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic wait_sends(input int n, input string tag);
    int c;
    c = 0;
    while (snd_op_q.size() < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_reach"}, snd_op_q.size() >= n, 1);
  endtask

  // Reference: outcome of a run from the table and reply plan.
  task automatic run_model(input int l);
    int n, drops, sends;
    n = (l > 16) ? 16 : l;
    exp_op_q.delete();
    exp_dat_q.delete();
    e_err = 0;
    e_fidx = 0;
    e_nret = 0;
    e_nresp = 0;
    for (int i = 0; i < n; i++) begin
      drops = drop_by_cmd[t_cmd[i]];
      sends = (drops > MR) ? MR + 1 : drops + 1;
      for (int s = 0; s < sends; s++) begin
        exp_op_q.push_back(t_cmd[i]);
        exp_dat_q.push_back(t_dat[i]);
      end
      e_nret += sends - 1;
      if (drops > MR) begin
        e_err = 2;
        e_fidx = i;
        break;
      end
      e_nresp++;
      if (t_chk[i] && rsp_by_cmd[t_cmd[i]] != t_exp[i]) begin
        e_err = 1;
        e_fidx = i;
        break;
      end
    end
    e_pass = (e_err == 0) ? 1 : 0;
  endtask

  task automatic check_results(input string tag, input int l);
    int m;
    run_model(l);
    check({tag, "_nsnd"}, snd_op_q.size(), exp_op_q.size());
    m = (snd_op_q.size() < exp_op_q.size()) ?
        snd_op_q.size() : exp_op_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_op%0d", tag, i), snd_op_q[i], exp_op_q[i]);
      check($sformatf("%s_dat%0d", tag, i), snd_dat_q[i], exp_dat_q[i]);
    end
    check({tag, "_pass"}, o_pass, e_pass);
    check({tag, "_err"}, o_err, e_err);
    check({tag, "_fidx"}, o_fidx, e_fidx);
    check({tag, "_nret"}, o_nret, e_nret);
    check({tag, "_nclr"}, n_clr - clr0, e_nresp);
  endtask

  initial begin
    int l, d0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_cmd = '0;
    wr_data = '0;
    wr_exp = '0;
    wr_chk = 1'b0;
    len = '0;
    start = 1'b0;
    abort = 1'b0;
    exact_to = 1'b0;
    hold_snt = 1'b0;
    run_id = 0;
    clear_plan();
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", outs(), 0);

    wr(0, 8'h01, 16'h0000, 8'hC0, 1);
    wr(1, 8'h02, 16'h00FA, 8'hA5, 1);
    wr(2, 8'h05, 16'h00FD, 8'hA5, 1);
    wr(3, 8'h08, 16'h0000, 8'hA5, 1);
    for (int i = 0; i < 4; i++) rsp_by_cmd[t_cmd[i]] = t_exp[i];
    start_run(4);
    check("t1_busy", busy, 1);
    wait_done("t1");
    check_results("t1", 4);

    rsp_by_cmd[8'h02] = 8'hFF;
    start_run(4);
    wait_done("t2a");
    check_results("t2a", 4);
    wr(1, 8'h02, 16'h00FA, 8'hA5, 0);
    start_run(4);
    wait_done("t2b");
    check_results("t2b", 4);
    wr(1, 8'h02, 16'h00FA, 8'hA5, 1);
    rsp_by_cmd[8'h02] = 8'hA5;

    drop_by_cmd[8'h01] = 2;
    start_run(4);
    wait_done("t3a");
    check_results("t3a", 4);
    drop_by_cmd[8'h01] = 3;
    start_run(4);
    wait_done("t3b");
    check_results("t3b", 4);
    drop_by_cmd[8'h01] = 0;

    start_run(0);
    wait_done("t4_len0");
    check("t4_len0_lat", lat, 0);
    check_results("t4_len0", 0);

    start_run(4);
    wait_sends(2, "t4_mid");
    start = 1'b1;
    wr_en = 1'b1;
    wr_addr = 4'd2;
    wr_cmd = 8'h77;
    wr_data = 16'hBEEF;
    wr_exp = 8'h00;
    wr_chk = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    wait_done("t4_busy");
    check_results("t4_busy", 4);
    start_run(4);
    wait_done("t4_after");
    check_results("t4_after", 4);

    drop_by_cmd[8'h05] = 5;
    start_run(4);
    wait_sends(3, "t5_abort");
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_done", done, 1);
    check("t5_abort_err", err_code, 3);
    check("t5_abort_fidx", fail_idx, 2);
    check("t5_abort_pass", pass, 0);
    repeat (100) @(negedge clk);
    check("t5_abort_nsnd", snd_op_q.size(), 3);
    drop_by_cmd[8'h05] = 0;

    hold_snt = 1'b1;
    start_run(4);
    wait_sends(1, "t5_rst");
    repeat (2) @(negedge clk);
    check("t5_wsnt_busy", busy, 1);
    d0 = n_done;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_outs", outs(), 0);
    rst = 1'b0;
    hold_snt = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_rst_nodone", n_done - d0, 0);
    check("t5_rst_idle", outs(), 0);
    start_run(4);
    wait_done("t5_rerun");
    check_results("t5_rerun", 4);

    exact_to = 1'b1;
    start_run(4);
    wait_done("t6");
    check_results("t6", 4);
    exact_to = 1'b0;

    for (int r = 0; r < 10; r++) begin
      clear_plan();
      for (int i = 0; i < 16; i++) begin
        wr(i, {4'(i), 4'($urandom)}, 16'($urandom),
           8'($urandom), 1'($urandom));
        rsp_by_cmd[t_cmd[i]] = ($urandom_range(0, 3) == 0) ?
                               8'($urandom) : t_exp[i];
        drop_by_cmd[t_cmd[i]] = ($urandom_range(0, 5) == 0) ?
                                $urandom_range(1, 3) : 0;
      end
      l = ($urandom_range(0, 3) == 0) ?
          $urandom_range(17, 31) : $urandom_range(1, 16);
      start_run(l);
      wait_done($sformatf("rnd%0d", r));
      check_results($sformatf("rnd%0d", r), l);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
